// File: rtl/traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Purpose: sequences a two-approach intersection (north-south / east-west)
// through green, yellow and all-red clearance phases, with an optional
// pedestrian walk phase and a flashing-yellow fault/night mode.
// Phase durations come from an external seconds timer: this block publishes
// the duration on 'delay', restarts the timer with a one-cycle 'tmr_clear'
// pulse on every phase entry (and every flash toggle), and advances when the
// timer reports 'timeout'.
//
// Ports:
//   clk        system clock
//   reset      asynchronous, active-high reset
//   timeout    from the seconds timer, high when elapsed >= delay
//   ped_req    pedestrian request (level or pulse)
//   flash_en   fault/night mode request
//   tmr_clear  registered one-cycle pulse restarting the seconds timer
//   delay      registered duration of the current phase, in seconds
//   ns_light   registered {red,yellow,green} for north-south
//   ew_light   registered {red,yellow,green} for east-west
//   ped_walk   registered walk indication
//   phase      registered state code, for debug
// ---------------------------------------------------------------------------
module traffic_phase_sequencer #(
    parameter int unsigned T_GREEN  = 10,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 1,
    parameter int unsigned T_WALK   = 5,
    parameter int unsigned T_FLASH  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        timeout,
    input  logic        ped_req,
    input  logic        flash_en,
    output logic        tmr_clear,
    output logic [31:0] delay,
    output logic [2:0]  ns_light,
    output logic [2:0]  ew_light,
    output logic        ped_walk,
    output logic [2:0]  phase
);

    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        ALLRED_1  = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        ALLRED_2  = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    state_t state;
    state_t state_nxt;
    logic   settled;
    logic   ped_pending;
    logic   ped_pending_nxt;
    logic   flash_on;
    logic   flash_on_nxt;
    logic   qual_timeout;
    logic   restart;

    // The timer output is stale for the entry cycle (tmr_clear still high)
    // and the cycle after it (timer has only just been cleared), so both are
    // blanked before a timeout may advance the sequence.
    assign qual_timeout = timeout & ~tmr_clear & settled;

    function automatic logic [31:0] delay_of(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   delay_of = T_GREEN;
            NS_YELLOW, EW_YELLOW: delay_of = T_YELLOW;
            PED_WALK:             delay_of = T_WALK;
            FLASH:                delay_of = T_FLASH;
            default:              delay_of = T_ALLRED;
        endcase
    endfunction

    function automatic logic [2:0] ns_of(input state_t s, input logic fon);
        case (s)
            NS_GREEN:  ns_of = GRN;
            NS_YELLOW: ns_of = YEL;
            FLASH:     ns_of = fon ? YEL : OFF;
            default:   ns_of = RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_of(input state_t s, input logic fon);
        case (s)
            EW_GREEN:  ew_of = GRN;
            EW_YELLOW: ew_of = YEL;
            FLASH:     ew_of = fon ? YEL : OFF;
            default:   ew_of = RED;
        endcase
    endfunction

    // Next-state selection. flash_en wins over a simultaneous timeout;
    // leaving FLASH goes straight to the second clearance phase so that the
    // normal cycle restarts from an all-red state.
    always_comb begin
        state_nxt    = state;
        flash_on_nxt = flash_on;
        if (state != FLASH && flash_en) begin
            state_nxt    = FLASH;
            flash_on_nxt = 1'b1;
        end else if (state == FLASH) begin
            if (!flash_en) begin
                state_nxt    = ALLRED_2;
                flash_on_nxt = 1'b0;
            end else if (qual_timeout) begin
                flash_on_nxt = ~flash_on;
            end
        end else if (qual_timeout) begin
            case (state)
                NS_GREEN:  state_nxt = NS_YELLOW;
                NS_YELLOW: state_nxt = ALLRED_1;
                ALLRED_1:  state_nxt = EW_GREEN;
                EW_GREEN:  state_nxt = EW_YELLOW;
                EW_YELLOW: state_nxt = ALLRED_2;
                ALLRED_2: begin
                    if (ped_pending) state_nxt = PED_WALK;
                    else             state_nxt = NS_GREEN;
                end
                default:   state_nxt = NS_GREEN;
            endcase
        end
    end

    // A flash toggle restarts the timer just like a phase entry does.
    assign restart = (state_nxt != state) || (flash_on_nxt != flash_on);

    // Entering the walk phase serves the request; requests during the walk
    // are ignored rather than queued for the next cycle.
    always_comb begin
        ped_pending_nxt = ped_pending;
        if (state_nxt == PED_WALK && state != PED_WALK) begin
            ped_pending_nxt = 1'b0;
        end else if (ped_req && state != PED_WALK) begin
            ped_pending_nxt = 1'b1;
        end
    end

    // All outputs are registered from the next state so that they change
    // in the same cycle the state does.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ALLRED_2;
            tmr_clear   <= 1'b1;
            settled     <= 1'b0;
            ped_pending <= 1'b0;
            flash_on    <= 1'b0;
            delay       <= T_ALLRED;
            ns_light    <= RED;
            ew_light    <= RED;
            ped_walk    <= 1'b0;
            phase       <= ALLRED_2;
        end else begin
            state       <= state_nxt;
            tmr_clear   <= restart;
            settled     <= ~tmr_clear;
            ped_pending <= ped_pending_nxt;
            flash_on    <= flash_on_nxt;
            delay       <= delay_of(state_nxt);
            ns_light    <= ns_of(state_nxt, flash_on_nxt);
            ew_light    <= ew_of(state_nxt, flash_on_nxt);
            ped_walk    <= (state_nxt == PED_WALK);
            phase       <= state_nxt;
        end
    end

endmodule
